sevenseg_scan_capture: RTL

- Receiving end of the multiplexed seven-segment display bus: watches the active-low anode and cathode lines driven by the dual seven-segment display driver.
- Recovers the digit value shown on each scanned position and presents it as 4-bit codes with per-digit valid flags.
- Used for on-board loopback checking of the BCD counter and display path, and as a bench monitor.
- Samples in the 5 MHz system clock domain; the display bus is treated as asynchronous.

---
 rtl/sevenseg_pkg.sv | 77 +++++++
 rtl/sevenseg_scan_capture_if.sv | 23 ++
 rtl/sevenseg_glyph_decode.sv | 17 +
 rtl/sevenseg_scan_capture.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared definitions for seven-segment bus capture: glyph table, decode helper,
// FSM state encoding and a one-hot index helper.
package sevenseg_pkg;

   // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] GLYPH_0 = 7'h40;
   localparam logic [6:0] GLYPH_1 = 7'h79;
   localparam logic [6:0] GLYPH_2 = 7'h24;
   localparam logic [6:0] GLYPH_3 = 7'h30;
   localparam logic [6:0] GLYPH_4 = 7'h19;
   localparam logic [6:0] GLYPH_5 = 7'h12;
   localparam logic [6:0] GLYPH_6 = 7'h02;
   localparam logic [6:0] GLYPH_7 = 7'h78;
   localparam logic [6:0] GLYPH_8 = 7'h00;
   localparam logic [6:0] GLYPH_9 = 7'h10;
   localparam logic [6:0] GLYPH_A = 7'h08;
   localparam logic [6:0] GLYPH_B = 7'h03;
   localparam logic [6:0] GLYPH_C = 7'h46;
   localparam logic [6:0] GLYPH_D = 7'h21;
   localparam logic [6:0] GLYPH_E = 7'h06;
   localparam logic [6:0] GLYPH_F = 7'h0E;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef struct packed {
      logic [3:0] code;
      logic       legal;
      logic       blank;
   } glyph_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_HELD   = 2'd2
   } state_t;

   function automatic glyph_t glyph_lookup(input logic [6:0] seg);
      glyph_t g;
      g.code  = 4'h0;
      g.legal = 1'b1;
      g.blank = 1'b0;
      case (seg)
         GLYPH_0: g.code = 4'h0;
         GLYPH_1: g.code = 4'h1;
         GLYPH_2: g.code = 4'h2;
         GLYPH_3: g.code = 4'h3;
         GLYPH_4: g.code = 4'h4;
         GLYPH_5: g.code = 4'h5;
         GLYPH_6: g.code = 4'h6;
         GLYPH_7: g.code = 4'h7;
         GLYPH_8: g.code = 4'h8;
         GLYPH_9: g.code = 4'h9;
         GLYPH_A: g.code = 4'hA;
         GLYPH_B: g.code = 4'hB;
         GLYPH_C: g.code = 4'hC;
         GLYPH_D: g.code = 4'hD;
         GLYPH_E: g.code = 4'hE;
         GLYPH_F: g.code = 4'hF;
         SEG_BLANK: begin
            g.legal = 1'b0;
            g.blank = 1'b1;
         end
         default: g.legal = 1'b0;
      endcase
      return g;
   endfunction

   // Index of the highest set bit; only meaningful when exactly one bit is set
   function automatic logic [2:0] onehot_index(input logic [7:0] v);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (v[i]) idx = 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/sevenseg_scan_capture_if.sv
// Display bus plus recovered-digit outputs; master is the display side / observer,
// slave is the capture block.
interface sevenseg_scan_capture_if #(
   parameter int NUM_DIGITS = 2
);
   logic [7:0]              anodes;
   logic [6:0]              cathodes;
   logic [4*NUM_DIGITS-1:0] digits;
   logic [NUM_DIGITS-1:0]   digit_valid;
   logic                    update;
   logic                    decode_error;
   logic                    scan_timeout;

   modport master (
      output anodes, cathodes,
      input  digits, digit_valid, update, decode_error, scan_timeout
   );

   modport slave (
      input  anodes, cathodes,
      output digits, digit_valid, update, decode_error, scan_timeout
   );
endinterface

// File: rtl/sevenseg_glyph_decode.sv
// Combinational active-low segment pattern to hex code decoder with blank and
// legal flags; reusable by other display checkers.
module sevenseg_glyph_decode
   import sevenseg_pkg::*;
(
   input  logic [6:0] cathodes,
   output logic [3:0] code,
   output logic       is_blank,
   output logic       is_legal
);
   glyph_t g;

   assign g        = glyph_lookup(cathodes);
   assign code     = g.code;
   assign is_blank = g.blank;
   assign is_legal = g.legal;
endmodule

// File: rtl/sevenseg_scan_capture.sv
// Recovers per-position digit codes from an asynchronous multiplexed
// seven-segment bus once a qualified anode/cathode pair has been stable.
//
// state     | meaning
// ST_IDLE   | no single in-range anode active
// ST_SETTLE | qualified pair present, waiting for STABLE_CYCLES identical samples
// ST_HELD   | pair captured, waiting for it to change
module sevenseg_scan_capture
   import sevenseg_pkg::*;
#(
   parameter int NUM_DIGITS     = 2,
   parameter int STABLE_CYCLES  = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic                    clk,
   input  logic                    reset,
   sevenseg_scan_capture_if.slave  bus
);
   localparam int SW = $clog2(STABLE_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [7:0]              an_s1, an_s2;
   logic [6:0]              cat_s1, cat_s2;
   logic [14:0]             pair_prev;
   logic [SW-1:0]           stable_cnt, stable_next;
   logic                    pair_changed;
   logic [2:0]              sel_idx;
   logic                    qualified;
   logic                    capture;
   logic [3:0]              code;
   logic                    is_blank, is_legal;
   logic [3:0]              cur_code;
   logic                    cur_valid;
   logic                    cap_changed;

   state_t                  state;
   logic [4*NUM_DIGITS-1:0] digits_q;
   logic [NUM_DIGITS-1:0]   valid_q;
   logic                    upd_pend, err_pend;
   logic                    update_q, err_q, timeout_q;
   logic [TW-1:0]           tmo_cnt;

   // Bus idles high, so synchronizers and the previous pair reset to all ones
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         an_s1      <= '1;
         an_s2      <= '1;
         cat_s1     <= '1;
         cat_s2     <= '1;
         pair_prev  <= '1;
         stable_cnt <= '0;
      end else begin
         an_s1      <= bus.anodes;
         an_s2      <= an_s1;
         cat_s1     <= bus.cathodes;
         cat_s2     <= cat_s1;
         pair_prev  <= {an_s2, cat_s2};
         stable_cnt <= stable_next;
      end
   end

   assign pair_changed = ({an_s2, cat_s2} != pair_prev);

   always_comb begin
      stable_next = stable_cnt;
      if (pair_changed)
         stable_next = SW'(1);
      else if (stable_cnt != SW'(STABLE_CYCLES))
         stable_next = stable_cnt + 1'b1;
   end

   assign sel_idx   = onehot_index(~an_s2);
   assign qualified = $onehot(~an_s2) && ({29'd0, sel_idx} < NUM_DIGITS);
   assign capture   = (state == ST_SETTLE) && qualified &&
                      (stable_next == SW'(STABLE_CYCLES));

   sevenseg_glyph_decode u_decode (
      .cathodes (cat_s2),
      .code     (code),
      .is_blank (is_blank),
      .is_legal (is_legal)
   );

   always_comb begin
      cur_code  = '0;
      cur_valid = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (sel_idx == 3'(i)) begin
            cur_code  = digits_q[4*i +: 4];
            cur_valid = valid_q[i];
         end
      end
   end

   // Blank or illegal patterns leave the stored code alone, so only validity can change
   assign cap_changed = (is_legal != cur_valid) || (is_legal && (code != cur_code));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         digits_q  <= '0;
         valid_q   <= '0;
         upd_pend  <= 1'b0;
         err_pend  <= 1'b0;
         update_q  <= 1'b0;
         err_q     <= 1'b0;
         timeout_q <= 1'b0;
         tmo_cnt   <= '0;
      end else begin
         update_q <= upd_pend;
         err_q    <= err_pend;
         upd_pend <= 1'b0;
         err_pend <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (qualified) state <= ST_SETTLE;
            end
            ST_SETTLE: begin
               if (!qualified)   state <= ST_IDLE;
               else if (capture) state <= ST_HELD;
            end
            ST_HELD: begin
               if (pair_changed) state <= qualified ? ST_SETTLE : ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase

         // A capture on the same edge as the timeout wins
         if (capture) begin
            tmo_cnt   <= '0;
            timeout_q <= 1'b0;
            upd_pend  <= cap_changed;
            err_pend  <= !is_legal && !is_blank;
            for (int i = 0; i < NUM_DIGITS; i++) begin
               if (sel_idx == 3'(i)) begin
                  valid_q[i] <= is_legal;
                  if (is_legal) digits_q[4*i +: 4] <= code;
               end
            end
         end else if (tmo_cnt != TW'(TIMEOUT_CYCLES)) begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
               timeout_q <= 1'b1;
               valid_q   <= '0;
            end
         end
      end
   end

   assign bus.digits       = digits_q;
   assign bus.digit_valid  = valid_q;
   assign bus.update       = update_q;
   assign bus.decode_error = err_q;
   assign bus.scan_timeout = timeout_q;

endmodule
